// File: rtl/hwag_wheel_pkg.sv
// hwag_wheel_pkg: shared config record, widths and helpers for the trigger-wheel generator
package hwag_wheel_pkg;

    localparam int CFG_IDX_W  = 8;
    localparam int CFG_PRE_W  = 16;
    localparam int CFG_HALF_W = 16;

    typedef struct packed {
        logic [CFG_PRE_W-1:0]  presc;
        logic [CFG_HALF_W-1:0] half;
        logic [CFG_IDX_W-1:0]  teeth;
        logic [CFG_IDX_W-1:0]  missing;
        logic [CFG_IDX_W-1:0]  cam_on;
        logic [CFG_IDX_W-1:0]  cam_off;
    } wheel_cfg_t;

    // A config is usable only if every tooth index it names exists on the wheel
    function automatic logic cfg_valid(input wheel_cfg_t c);
        return (c.half != '0) && (c.teeth >= CFG_IDX_W'(2)) && (c.missing < c.teeth)
            && (c.cam_on < c.teeth) && (c.cam_off < c.teeth);
    endfunction

    // Cam window test; on>off means the window wraps through tooth 0, on==off means empty
    function automatic logic cam_hit(input wheel_cfg_t c, input logic [CFG_IDX_W-1:0] idx,
                                     input logic ph);
        return ph && ((c.cam_on < c.cam_off) ? (idx >= c.cam_on && idx < c.cam_off)
                                             : (c.cam_on > c.cam_off) && (idx >= c.cam_on || idx < c.cam_off));
    endfunction

endpackage

// File: rtl/hwag_wheel_tick.sv
// hwag_wheel_tick: clock prescaler producing a one-cycle tick every presc+1 clocks
module hwag_wheel_tick
    import hwag_wheel_pkg::*;
#(
    parameter int PRE_W = CFG_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [PRE_W-1:0] presc,
    output logic             tick
);

    logic [PRE_W-1:0] scnt;

    assign tick = !clr && (scnt == presc);

    // scnt runs 0..presc and restarts; clr holds it at 0 so the first tick lands presc+1 clocks after release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) scnt <= '0;
        else      scnt <= (clr || scnt == presc) ? '0 : scnt + PRE_W'(1);
    end

endmodule

// File: rtl/hwag_wheel_gen.sv
// hwag_wheel_gen: configurable N-M crank wheel and cam pulse generator with revolution-aligned config updates
module hwag_wheel_gen
    import hwag_wheel_pkg::*;
#(
    parameter int IDX_W  = CFG_IDX_W,
    parameter int PRE_W  = CFG_PRE_W,
    parameter int HALF_W = CFG_HALF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_wr,
    input  logic [PRE_W-1:0]  cfg_presc,
    input  logic [HALF_W-1:0] cfg_half,
    input  logic [IDX_W-1:0]  cfg_teeth,
    input  logic [IDX_W-1:0]  cfg_missing,
    input  logic [IDX_W-1:0]  cfg_cam_on,
    input  logic [IDX_W-1:0]  cfg_cam_off,
    output logic              vr_out,
    output logic              cam_out,
    output logic [IDX_W-1:0]  tooth_idx,
    output logic              cam_phase,
    output logic              rev_stb,
    output logic              cfg_pend,
    output logic              cfg_err
);

    wheel_cfg_t        act, pend, act_nxt, cfg_in;
    logic              run, tick, end_tooth, wrap, apply, present;
    logic [HALF_W:0]   tckc, per_m1, half_m1;
    logic [IDX_W-1:0]  idx_nxt;
    logic              phase_nxt;

    assign cfg_in = '{presc: cfg_presc, half: cfg_half, teeth: cfg_teeth, missing: cfg_missing,
                      cam_on: cfg_cam_on, cam_off: cfg_cam_off};

    // A halted generator (disabled or invalid config) has no revolution boundary to wait for
    assign run       = en && cfg_valid(act);
    assign per_m1    = {act.half, 1'b0} - (HALF_W+1)'(1);
    assign half_m1   = {1'b0, act.half} - (HALF_W+1)'(1);
    assign end_tooth = tick && (tckc == per_m1);
    assign wrap      = end_tooth && (tooth_idx == act.teeth - IDX_W'(1));
    assign apply     = cfg_pend && (wrap || !run);
    assign act_nxt   = apply ? pend : act;
    assign present   = tooth_idx < act.teeth - act.missing;
    assign idx_nxt   = wrap ? '0 : tooth_idx + IDX_W'(1);
    assign phase_nxt = cam_phase ^ wrap;

    hwag_wheel_tick #(.PRE_W(PRE_W)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clr   (!run),
        .presc (act.presc),
        .tick  (tick)
    );

    // Double-buffered config: the pending set is promoted at a wrap or while halted; a coincident write stays pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act      <= '0;
            pend     <= '0;
            cfg_pend <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            if (apply) begin
                act     <= pend;
                cfg_err <= !cfg_valid(pend);
            end
            if (cfg_wr) pend <= cfg_in;
            cfg_pend <= cfg_wr || (cfg_pend && !apply);
        end
    end

    // Tooth timing: vr low in the first half and high in the second half of present teeth; cam follows the new tooth index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tckc      <= '0;
            tooth_idx <= '0;
            cam_phase <= 1'b0;
            vr_out    <= 1'b0;
            cam_out   <= 1'b0;
            rev_stb   <= 1'b0;
        end else if (!run) begin
            tckc      <= '0;
            tooth_idx <= '0;
            cam_phase <= 1'b0;
            vr_out    <= 1'b0;
            cam_out   <= 1'b0;
            rev_stb   <= 1'b0;
        end else begin
            rev_stb <= wrap;
            if (tick) begin
                tckc   <= end_tooth ? '0 : tckc + (HALF_W+1)'(1);
                vr_out <= (tckc == half_m1 && present) ? 1'b1 : end_tooth ? 1'b0 : vr_out;
            end
            if (end_tooth) begin
                tooth_idx <= idx_nxt;
                cam_phase <= phase_nxt;
                cam_out   <= cam_hit(act_nxt, idx_nxt, phase_nxt);
            end
        end
    end

endmodule

// File: tb/tb_hwag_wheel_gen.sv
// tb_hwag_wheel_gen: directed and random stimulus against a revolution-time reference model
module tb_hwag_wheel_gen;
    import hwag_wheel_pkg::*;

    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, cfg_wr = 1'b0;
    logic [15:0] cfg_presc = '0, cfg_half = '0;
    logic [7:0]  cfg_teeth = '0, cfg_missing = '0, cfg_cam_on = '0, cfg_cam_off = '0;
    logic        vr_out, cam_out, cam_phase, rev_stb, cfg_pend, cfg_err;
    logic [7:0]  tooth_idx;

    int total = 0, bad = 0;

    // model state: r = running clocks since the current revolution started
    wheel_cfg_t m_act, m_pend;
    bit         m_pf, m_err, m_ph, m_rv;
    longint     r;
    longint     e_idx;
    bit         e_vr, e_cam;

    hwag_wheel_gen dut (
        .clk(clk), .rst(rst), .en(en), .cfg_wr(cfg_wr),
        .cfg_presc(cfg_presc), .cfg_half(cfg_half), .cfg_teeth(cfg_teeth),
        .cfg_missing(cfg_missing), .cfg_cam_on(cfg_cam_on), .cfg_cam_off(cfg_cam_off),
        .vr_out(vr_out), .cam_out(cam_out), .tooth_idx(tooth_idx), .cam_phase(cam_phase),
        .rev_stb(rev_stb), .cfg_pend(cfg_pend), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ok_cfg(input wheel_cfg_t c);
        return c.half >= 1 && c.teeth >= 2 && c.missing < c.teeth && c.cam_on < c.teeth && c.cam_off < c.teeth;
    endfunction

    function automatic longint rev_len(input wheel_cfg_t c);
        return longint'(c.teeth) * 2 * longint'(c.half) * (longint'(c.presc) + 1);
    endfunction

    function automatic bit in_window(input wheel_cfg_t c, input longint t);
        if (c.cam_on < c.cam_off) return t >= c.cam_on && t < c.cam_off;
        if (c.cam_on > c.cam_off) return t >= c.cam_on || t < c.cam_off;
        return 0;
    endfunction

    task automatic model_reset();
        m_act = '0; m_pend = '0; m_pf = 0; m_err = 0; m_ph = 0; m_rv = 0; r = 0;
    endtask

    task automatic model_edge(input bit e, input bit w, input wheel_cfg_t cin);
        bit run, wrap, app;
        run  = e && ok_cfg(m_act);
        wrap = 0;
        if (run) begin
            if (r + 1 == rev_len(m_act)) begin wrap = 1; r = 0; m_ph = !m_ph; end
            else r++;
        end else begin
            r = 0; m_ph = 0;
        end
        m_rv = wrap;
        app  = m_pf && (wrap || !run);
        if (app) begin m_act = m_pend; m_err = !ok_cfg(m_pend); end
        if (w) m_pend = cin;
        m_pf = w || (m_pf && !app);
    endtask

    task automatic calc_exp();
        longint p, t, n, tk;
        p = longint'(m_act.presc) + 1;
        t = 2 * longint'(m_act.half);
        if (t == 0) begin e_idx = 0; tk = 0; end
        else begin n = r / p; e_idx = n / t; tk = n % t; end
        e_vr  = ok_cfg(m_act) && e_idx < longint'(m_act.teeth) - longint'(m_act.missing) && tk >= m_act.half;
        e_cam = m_ph && in_window(m_act, e_idx);
    endtask

    task automatic compare_all();
        calc_exp();
        check("idx", 32'(tooth_idx), 32'(e_idx));
        check("vr", 32'(vr_out), 32'(e_vr));
        check("cam", 32'(cam_out), 32'(e_cam));
        check("phase", 32'(cam_phase), 32'(m_ph));
        check("rev", 32'(rev_stb), 32'(m_rv));
        check("pend", 32'(cfg_pend), 32'(m_pf));
        check("err", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic set_cfg(input int p, input int h, input int t, input int m, input int on, input int off);
        cfg_presc = 16'(p); cfg_half = 16'(h); cfg_teeth = 8'(t);
        cfg_missing = 8'(m); cfg_cam_on = 8'(on); cfg_cam_off = 8'(off);
    endtask

    // one clock: drive at negedge, model the posedge, compare at the next negedge
    task automatic cyc(input bit e, input bit w);
        wheel_cfg_t cin;
        en = e; cfg_wr = w;
        cin = '{cfg_presc, cfg_half, cfg_teeth, cfg_missing, cfg_cam_on, cfg_cam_off};
        @(posedge clk);
        model_edge(e, w, cin);
        @(negedge clk);
        cfg_wr = 0;
        compare_all();
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0);
    endtask

    task automatic run_to_wrap();
        int i;
        for (i = 0; i < 40000 && !(ok_cfg(m_act) && r + 1 == rev_len(m_act)); i++) cyc(1, 0);
        check("wrap_reached", 32'(i < 40000), 32'd1);
    endtask

    initial begin
        int k;
        bit found, en_r;
        model_reset();
        #1;
        check("rst_vr", 32'(vr_out), 0);
        check("rst_idx", 32'(tooth_idx), 0);
        check("rst_pend", 32'(cfg_pend), 0);
        @(negedge clk);
        rst = 1;
        cyc(0, 0);

        // basic 6-1 wheel, applied while disabled
        set_cfg(0, 2, 6, 1, 0, 0);
        cyc(0, 1);
        cyc(0, 0);
        check("basic_pend_cleared", 32'(cfg_pend), 0);
        run_n(60);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin cyc(1, 0); found = rev_stb; end
        check("rev_seen", 32'(found), 1);
        k = 0; found = 0;
        for (int i = 0; i < 100 && !found; i++) begin cyc(1, 0); k++; found = rev_stb; end
        check("rev_period", 32'(k), 32'd24);

        // deferred config mid-revolution, then a second write exactly on the wrap
        run_n(7);
        set_cfg(0, 4, 6, 1, 0, 0);
        cyc(1, 1);
        run_n(3);
        check("pend_mid", 32'(cfg_pend), 1);
        run_to_wrap();
        set_cfg(0, 1, 6, 0, 5, 2);
        cyc(1, 1);
        check("pend_wrap", 32'(cfg_pend), 1);
        run_n(150);
        run_to_wrap();
        cyc(1, 0);
        run_n(60);

        // 60-2 with cam, applied while disabled, two full revolutions
        set_cfg(3, 32, 60, 2, 4, 54);
        cyc(0, 1);
        cyc(0, 0);
        run_n(2 * 15360 + 600);

        // invalid config reached through a wrap, then cleared while disabled
        set_cfg(0, 2, 3, 3, 0, 0);
        cyc(1, 1);
        run_to_wrap();
        cyc(1, 0);
        run_n(40);
        check("err_set", 32'(cfg_err), 1);
        set_cfg(0, 2, 6, 1, 0, 0);
        cyc(0, 1);
        cyc(0, 0);
        check("err_cleared", 32'(cfg_err), 0);

        // random configs, writes and enable toggles
        en_r = 1;
        for (int i = 0; i < 4000; i++) begin
            bit w;
            int t;
            if ($urandom_range(0, 599) == 0) en_r = !en_r;
            w = ($urandom_range(0, 149) == 0);
            if (w) begin
                t = $urandom_range(2, 9);
                set_cfg($urandom_range(0, 2), $urandom_range(1, 3), t, $urandom_range(0, t - 1),
                        $urandom_range(0, t - 1), $urandom_range(0, t - 1));
                if ($urandom_range(0, 9) == 0) cfg_missing = cfg_teeth;
            end
            cyc(en_r, w);
        end

        // asynchronous reset mid-tooth while vr is high and a config is pending
        set_cfg(0, 2, 6, 1, 0, 0);
        cyc(0, 1);
        cyc(0, 0);
        set_cfg(1, 3, 5, 0, 1, 3);
        cyc(1, 1);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin cyc(1, 0); found = e_vr; end
        check("vr_high_before_rst", 32'(vr_out), 1);
        #2 rst = 0;
        #1;
        check("arst_vr", 32'(vr_out), 0);
        check("arst_idx", 32'(tooth_idx), 0);
        check("arst_pend", 32'(cfg_pend), 0);
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1;
        run_n(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hwag_wheel_gen.md
Name: hwag_wheel_gen

Overview:
- Synthesizable, runtime-configurable crank/cam trigger-wheel generator: produces a VR-style crank pulse train (N-M wheel) and a cam pulse every second revolution.
- Drives hwag vr_in/cam inputs in benches and on FPGA self-test builds, replacing hard-coded 60-2 stimulus.
- Generalised in wheel geometry, tooth timing and cam window.
- Config changes are double-buffered and take effect only at a revolution boundary.

Parameters:
- IDX_W, 8, width of tooth index and tooth-count config
- PRE_W, 16, width of clock prescaler
- HALF_W, 16, width of half-tooth tick count

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  generator enable; low forces idle state
- cfg_wr  in  1  one-cycle strobe, captures cfg_* into pending set
- cfg_presc  in  PRE_W  ticks occur every cfg_presc+1 clk
- cfg_half  in  HALF_W  ticks per half tooth period; tooth period = 2*cfg_half ticks
- cfg_teeth  in  IDX_W  total tooth positions per revolution, including missing
- cfg_missing  in  IDX_W  missing teeth at the end of the revolution
- cfg_cam_on  in  IDX_W  tooth index where cam rises (phase 1 only)
- cfg_cam_off  in  IDX_W  tooth index where cam falls (phase 1 only)
- vr_out  out  1  crank tooth signal
- cam_out  out  1  cam signal
- tooth_idx  out  IDX_W  current tooth position 0..teeth-1
- cam_phase  out  1  revolution parity
- rev_stb  out  1  one-cycle pulse when tooth_idx wraps to 0
- cfg_pend  out  1  pending config not yet applied
- cfg_err  out  1  active config invalid, generator halted

Behaviour:
- Reset, async on rst=0: all counters 0; outputs 0; active and pending config 0; cfg_pend=0.
- Prescaler scnt counts 0..presc; tick=1 in the cycle scnt==presc, then scnt returns to 0.
- On tick:
  - tckc increments.
  - When tckc==2*half-1, tckc returns to 0 and tooth_idx advances.
  - When tooth_idx==teeth-1, tooth_idx wraps to 0, cam_phase toggles, and rev_stb=1 in the next cycle.
- Tooth idx is "missing" when idx >= teeth-missing.
- vr_out is registered:
  - Sets on tick with tckc==half-1 for a present tooth.
  - Clears on tick with tckc==2*half-1.
  - Never rises in a missing tooth.
  - Net effect: low first half, high second half of each present tooth.
- cam_out is registered and updates when tooth_idx changes:
  - If cam_phase=1 and cam_on<cam_off: cam=1 iff cam_on<=idx<cam_off.
  - If cam_on>cam_off, the window wraps: cam=1 iff idx>=cam_on or idx<cam_off.
  - cam_on==cam_off gives cam=0.
  - cam_phase=0 gives cam=0.
- Config path:
  - cfg_wr loads the pending set and sets cfg_pend.
  - A second cfg_wr before apply overwrites pending.
  - Pending is applied, and cfg_pend cleared, in the same cycle as tooth_idx wraps to 0, or immediately when en=0.
  - cfg_wr coincident with a wrap: the old pending set is applied and the new one stays pending.
- Validity: active config is valid iff half>=1, teeth>=2, missing<teeth, cam_on<teeth, cam_off<teeth.
  - Invalid config: cfg_err=1, counters held at 0, vr/cam low.
  - A valid config applied while en=0 clears cfg_err.
- en=0: scnt, tckc, tooth_idx, cam_phase and outputs are synchronously cleared.
- en rising: the first tick occurs presc+1 cycles later.
- missing=0 gives a plain N-tooth wheel.
- All arithmetic is unsigned.
- 2*half is computed in HALF_W+1 bits so half=2^HALF_W-1 does not overflow.

Decomposition:
- Package hwag_wheel_pkg: cfg struct typedef (presc, half, teeth, missing, cam_on, cam_off) and width localparams.
- One sub-module hwag_wheel_tick (prescaler plus tick strobe).
- Tooth/cam logic stays in the top.

Test Plan:
- Basic N-M wheel: presc=0, half=2, teeth=6, missing=1, en=1.
  - vr_out high 2 clk, low 2 clk for idx 0..4.
  - Low 4 clk at idx 5.
  - rev_stb every 24 clk.
- 60-2 with cam: presc=3, half=32, teeth=60, missing=2, cam_on=4, cam_off=54.
  - Gap low for 2*64*4 clk.
  - cam_out high idx 4..53 only on odd cam_phase.
- Deferred config: mid-revolution cfg_wr with half=4.
  - cfg_pend=1 until the wrap.
  - Tooth period changes exactly at idx 0.
  - Same-cycle wrap+cfg_wr keeps cfg_pend=1.
- Invalid config: teeth=3, missing=3.
  - cfg_err=1, vr/cam stay 0.
  - Valid cfg with en=0 clears cfg_err.
- Wrapped cam window: cam_on=5, cam_off=2, teeth=6 → cam high at idx 5,0,1 on phase 1.
- Reset: rst low mid-tooth with vr high → all outputs 0 immediately, pending config lost, cfg_pend=0.
